// File: rtl/i2s_capture_pkg.sv
// ---------------------------------------------------------------------------
// i2s_capture_pkg
// Shared types and sizing helpers for the I2S-to-AXI-Stream capture path.
//   cap_state_t  : capture FSM states (IDLE, WAIT, SHIFT, PUSH)
//   data_width() : frame word width for a given channel count / kept bits
//   level_width(): width of a FIFO occupancy count (0..depth inclusive)
// ---------------------------------------------------------------------------
package i2s_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SHIFT,
      ST_PUSH
   } cap_state_t;

   // Default-configuration widths (8 channels x 16 bits, 16-deep FIFO).
   localparam int DEF_NUM_CH     = 8;
   localparam int DEF_OUT_W      = 16;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_DATA_W     = DEF_NUM_CH * DEF_OUT_W;
   localparam int DEF_LEVEL_W    = $clog2(DEF_FIFO_DEPTH) + 1;

   function automatic int data_width(input int num_ch, input int out_w);
      return num_ch * out_w;
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_frame_fifo.sv
// ---------------------------------------------------------------------------
// axis_frame_fifo
// Synchronous show-ahead FIFO. The head word is always visible on rdata
// (forced to zero while empty). A push into a full FIFO is accepted when a
// pop happens on the same edge.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : write request and data
//   pop             : read request (ignored while empty)
//   rdata           : head word
//   full, empty     : status flags
//   level           : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module axis_frame_fifo
   import i2s_capture_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot the push needs.
   assign do_push = push && (!full || do_pop);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; only the pointers/count define
   // validity, and resetting the array would cost a reset net per bit.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr];
   assign level = count;

endmodule

// File: rtl/i2s_axis_capture.sv
// ---------------------------------------------------------------------------
// i2s_axis_capture
// Deserialises NUM_CH I2S data lines sharing one sck/ws pair, keeps the top
// OUT_W bits of the selected slot of every channel, packs them into one
// frame word, buffers frames and streams them out on AXI-Stream with tlast
// every PKT_LEN accepted beats.
// Ports:
//   sck, rst        : I2S bit clock, asynchronous active-high reset
//   start           : capture enable (level)
//   ws, sd          : I2S word select and NUM_CH serial data lines
//   S_AXIS_*        : AXI-Stream master towards the DMA (tdata ch0 in LSBs)
//   overflow_cnt    : saturating count of frames dropped on a full FIFO
//   frame_err       : sticky, a slot was cut short by a ws edge
//   fifo_level      : current FIFO occupancy
// ---------------------------------------------------------------------------
module i2s_axis_capture
   import i2s_capture_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int SLOT_W     = 32,
   parameter int OUT_W      = 16,
   parameter int RIGHT_SLOT = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int PKT_LEN    = 256,
   parameter int CNT_W      = 16
) (
   input  logic                          sck,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          ws,
   input  logic [NUM_CH-1:0]             sd,
   input  logic                          S_AXIS_tready,
   output logic [NUM_CH*OUT_W-1:0]       S_AXIS_tdata,
   output logic                          S_AXIS_tvalid,
   output logic                          S_AXIS_tlast,
   output logic [CNT_W-1:0]              overflow_cnt,
   output logic                          frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int   DATA_W    = data_width(NUM_CH, OUT_W);
   localparam int   BIT_W     = $clog2(SLOT_W + 1);
   localparam int   BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic SEL       = (RIGHT_SLOT != 0);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_W - 1);
   localparam logic [BIT_W-1:0]  KEEP_BITS = BIT_W'(OUT_W);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   cap_state_t        state;
   logic [BIT_W-1:0]  bit_cnt;
   logic              ws_d;
   logic [OUT_W-1:0]  shreg [NUM_CH];
   logic [DATA_W-1:0] frame_word;
   logic [BEAT_W-1:0] beat_cnt;

   logic slot_start;
   logic slot_end;
   logic push;
   logic pop;
   logic drop;
   logic fifo_full;
   logic fifo_empty;

   // ws entering the selected level opens a slot; leaving it closes one.
   assign slot_start = (ws_d != SEL) && (ws == SEL);
   assign slot_end   = (ws_d == SEL) && (ws != SEL);

   assign push = (state == ST_PUSH);
   assign pop  = S_AXIS_tvalid && S_AXIS_tready;
   assign drop = push && fifo_full && !pop;

   // Capture FSM. In I2S the ws edge that precedes the final bit of a slot
   // is normal; one seen earlier means the slot was cut short.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         ws_d         <= 1'b0;
         frame_err    <= 1'b0;
         overflow_cnt <= '0;
      end else begin
         ws_d <= ws;
         unique case (state)
            ST_IDLE: begin
               if (start) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!start) begin
                  state <= ST_IDLE;
               end else if (slot_start) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               if (!start) begin
                  state <= ST_IDLE;
               end else if (slot_end && (bit_cnt != LAST_BIT)) begin
                  frame_err <= 1'b1;
                  state     <= ST_WAIT;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) state <= ST_PUSH;
               end
            end
            ST_PUSH: begin
               if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
               state <= start ? ST_WAIT : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Only the first OUT_W bits of a slot (its MSBs) are ever used, so the
   // per-channel register stops shifting once it holds them. Data-only
   // flops: a complete slot always overwrites every kept bit before PUSH.
   always_ff @(posedge sck) begin
      if ((state == ST_SHIFT) && (bit_cnt < KEEP_BITS)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shreg[i] <= (shreg[i] << 1) | OUT_W'(sd[i]);
         end
      end
   end

   // NOTE: every combinational output gets a default first so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      frame_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         frame_word[i*OUT_W +: OUT_W] = shreg[i];
      end
   end

   axis_frame_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sck),
      .rst   (rst),
      .push  (push),
      .wdata (frame_word),
      .pop   (pop),
      .rdata (S_AXIS_tdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign S_AXIS_tvalid = !fifo_empty;

   // Counts accepted beats only, so dropped frames never shift packet
   // boundaries and tlast stays stable while the sink stalls.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
   end

   assign S_AXIS_tlast = S_AXIS_tvalid && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_i2s_axis_capture.sv
module tb_i2s_axis_capture;

   localparam int NCH   = 8;
   localparam int SW    = 32;
   localparam int OW    = 16;
   localparam int DW    = NCH * OW;
   localparam int DEPTH = 4;
   localparam int PLEN  = 4;
   localparam int CW    = 16;
   localparam int LW    = 3;

   typedef logic [NCH-1:0][SW-1:0] slots_t;
   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic            sck = 1'b0;
   logic            rst = 1'b0;
   logic            ws  = 1'b1;
   logic [NCH-1:0]  sd  = '0;
   logic            start1 = 1'b0, start2 = 1'b0;
   logic            tready1 = 1'b0, tready2 = 1'b0;

   logic [DW-1:0]   tdata1, tdata2;
   logic            tvalid1, tvalid2, tlast1, tlast2;
   logic [CW-1:0]   ovf1, ovf2;
   logic            ferr1, ferr2;
   logic [LW-1:0]   lvl1, lvl2;

   exp_t q1[$];
   exp_t q2[$];
   int   beat1 = 0, beat2 = 0;
   int   total = 0, bad = 0;

   i2s_axis_capture #(
      .NUM_CH(NCH), .SLOT_W(SW), .OUT_W(OW), .RIGHT_SLOT(0),
      .FIFO_DEPTH(DEPTH), .PKT_LEN(PLEN), .CNT_W(CW)
   ) dut_left (
      .sck(sck), .rst(rst), .start(start1), .ws(ws), .sd(sd),
      .S_AXIS_tready(tready1), .S_AXIS_tdata(tdata1), .S_AXIS_tvalid(tvalid1),
      .S_AXIS_tlast(tlast1), .overflow_cnt(ovf1), .frame_err(ferr1),
      .fifo_level(lvl1)
   );

   i2s_axis_capture #(
      .NUM_CH(NCH), .SLOT_W(SW), .OUT_W(OW), .RIGHT_SLOT(1),
      .FIFO_DEPTH(DEPTH), .PKT_LEN(PLEN), .CNT_W(CW)
   ) dut_right (
      .sck(sck), .rst(rst), .start(start2), .ws(ws), .sd(sd),
      .S_AXIS_tready(tready2), .S_AXIS_tdata(tdata2), .S_AXIS_tvalid(tvalid2),
      .S_AXIS_tlast(tlast2), .overflow_cnt(ovf2), .frame_err(ferr2),
      .fifo_level(lvl2)
   );

   always #5 sck = ~sck;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   // Scoreboards: inputs change on the falling edge, so at negedge+2 both the
   // outputs and tready hold the values the next rising edge will use.
   always begin
      @(negedge sck); #2;
      if (!rst && tvalid1 && tready1) begin
         total++;
         if (q1.size() == 0) begin
            bad++;
            $display("FAIL left_unexpected_beat got tdata=%h tlast=%b, required no beat", tdata1, tlast1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            if (tdata1 !== e.data || tlast1 !== e.last) begin
               bad++;
               $display("FAIL left_beat got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                        tdata1, tlast1, e.data, e.last);
            end
         end
      end
   end

   always begin
      @(negedge sck); #2;
      if (!rst && tvalid2 && tready2) begin
         total++;
         if (q2.size() == 0) begin
            bad++;
            $display("FAIL right_unexpected_beat got tdata=%h tlast=%b, required no beat", tdata2, tlast2);
         end else begin
            exp_t e;
            e = q2.pop_front();
            if (tdata2 !== e.data || tlast2 !== e.last) begin
               bad++;
               $display("FAIL right_beat got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                        tdata2, tlast2, e.data, e.last);
            end
         end
      end
   end

   function automatic logic [DW-1:0] pack_slots(input slots_t s);
      logic [DW-1:0] w;
      w = '0;
      for (int i = 0; i < NCH; i++) w[i*OW +: OW] = s[i][SW-1 -: OW];
      return w;
   endfunction

   function automatic slots_t rand_slots();
      slots_t s;
      for (int i = 0; i < NCH; i++) s[i] = $urandom;
      return s;
   endfunction

   task automatic expect1(input logic [DW-1:0] w);
      exp_t e;
      e.data = w;
      e.last = (beat1 == PLEN - 1);
      beat1  = (beat1 + 1) % PLEN;
      q1.push_back(e);
   endtask

   task automatic expect2(input logic [DW-1:0] w);
      exp_t e;
      e.data = w;
      e.last = (beat2 == PLEN - 1);
      beat2  = (beat2 + 1) % PLEN;
      q2.push_back(e);
   endtask

   // One I2S slot, MSB first; ws takes the next slot's level on the last bit.
   task automatic send_slot(input logic lvl, input slots_t d, input int len, input logic nxt);
      for (int b = 0; b < len; b++) begin
         @(negedge sck);
         ws = (b == len - 1) ? nxt : lvl;
         for (int i = 0; i < NCH; i++) sd[i] = d[i][SW-1-b];
      end
   endtask

   task automatic send_frame(input slots_t l, input slots_t r);
      send_slot(1'b1, r, SW, 1'b0);
      send_slot(1'b0, l, SW, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge sck);
      rst = 1'b1;
      repeat (2) @(negedge sck);
      rst = 1'b0;
      q1.delete();
      q2.delete();
      beat1 = 0;
      beat2 = 0;
   endtask

   task automatic wait_drain1(input string name);
      for (int c = 0; c < 400 && q1.size() != 0; c++) @(negedge sck);
      total++;
      if (q1.size() != 0) begin
         bad++;
         $display("FAIL %s_drain got %0d beats outstanding, required 0", name, q1.size());
      end
   endtask

   task automatic wait_drain2(input string name);
      for (int c = 0; c < 400 && q2.size() != 0; c++) @(negedge sck);
      total++;
      if (q2.size() != 0) begin
         bad++;
         $display("FAIL %s_drain got %0d beats outstanding, required 0", name, q2.size());
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      repeat (2) @(negedge sck);
      #2;
      total += 8;
      if (tvalid1 !== 1'b0) begin bad++; $display("FAIL reset_tvalid got %b required 0", tvalid1); end
      if (tlast1  !== 1'b0) begin bad++; $display("FAIL reset_tlast got %b required 0", tlast1); end
      if (tdata1  !== '0)   begin bad++; $display("FAIL reset_tdata got %h required 0", tdata1); end
      if (ovf1    !== '0)   begin bad++; $display("FAIL reset_overflow got %0d required 0", ovf1); end
      if (ferr1   !== 1'b0) begin bad++; $display("FAIL reset_frame_err got %b required 0", ferr1); end
      if (lvl1    !== '0)   begin bad++; $display("FAIL reset_level got %0d required 0", lvl1); end
      if ({tvalid2, tlast2, ferr2} !== 3'b000) begin bad++; $display("FAIL reset_right_flags got %b required 000", {tvalid2, tlast2, ferr2}); end
      if ({tdata2, ovf2, lvl2} !== '0) begin bad++; $display("FAIL reset_right_data got %h required 0", {tdata2, ovf2, lvl2}); end
      @(negedge sck);
      rst = 1'b0;
   endtask

   task automatic test_single();
      slots_t l;
      for (int i = 0; i < NCH; i++) l[i] = 32'hA5A5_0000 + i;
      start1  = 1'b1;
      tready1 = 1'b1;
      @(negedge sck);
      expect1({NCH{16'hA5A5}});
      send_frame(l, rand_slots());
      // Last bit is sampled on the next edge (enter PUSH); write one edge later.
      @(negedge sck); #2;
      total++;
      if (tvalid1 !== 1'b0) begin bad++; $display("FAIL single_latency_early got tvalid=%b required 0", tvalid1); end
      @(negedge sck); #2;
      total++;
      if (tvalid1 !== 1'b1) begin bad++; $display("FAIL single_latency got tvalid=%b required 1", tvalid1); end
      wait_drain1("single");
      @(negedge sck); #2;
      total++;
      if (tvalid1 !== 1'b0) begin bad++; $display("FAIL single_after got tvalid=%b required 0", tvalid1); end
   endtask

   task automatic test_packet();
      slots_t l;
      do_reset();
      start1  = 1'b1;
      tready1 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         l = rand_slots();
         expect1(pack_slots(l));
         send_frame(l, rand_slots());
      end
      wait_drain1("packet");
      total += 2;
      if (ferr1 !== 1'b0) begin bad++; $display("FAIL packet_frame_err got %b required 0", ferr1); end
      if (ovf1 !== '0) begin bad++; $display("FAIL packet_overflow got %0d required 0", ovf1); end
   endtask

   task automatic test_overflow();
      slots_t l, first;
      do_reset();
      start1  = 1'b1;
      tready1 = 1'b0;
      first   = '0;
      for (int k = 0; k < 7; k++) begin
         l = rand_slots();
         if (k == 0) first = l;
         if (k < DEPTH) expect1(pack_slots(l));
         send_frame(l, rand_slots());
      end
      repeat (3) @(negedge sck);
      #2;
      total += 4;
      if (lvl1 !== LW'(DEPTH)) begin bad++; $display("FAIL ovf_level got %0d required %0d", lvl1, DEPTH); end
      if (ovf1 !== CW'(3)) begin bad++; $display("FAIL ovf_count got %0d required 3", ovf1); end
      if (tdata1 !== pack_slots(first)) begin bad++; $display("FAIL ovf_stall_tdata got %h required %h", tdata1, pack_slots(first)); end
      if (tvalid1 !== 1'b1 || tlast1 !== 1'b0) begin bad++; $display("FAIL ovf_stall_flags got tvalid=%b tlast=%b required 1 0", tvalid1, tlast1); end
      @(negedge sck);
      tready1 = 1'b1;
      wait_drain1("overflow");
      @(negedge sck); #2;
      total += 2;
      if (lvl1 !== '0) begin bad++; $display("FAIL ovf_drained_level got %0d required 0", lvl1); end
      if (tvalid1 !== 1'b0) begin bad++; $display("FAIL ovf_drained_tvalid got %b required 0", tvalid1); end
   endtask

   task automatic test_short_slot();
      slots_t l;
      do_reset();
      start1  = 1'b1;
      tready1 = 1'b1;
      @(negedge sck);
      send_slot(1'b1, rand_slots(), SW, 1'b0);
      send_slot(1'b0, rand_slots(), 20, 1'b1);
      repeat (3) @(negedge sck);
      #2;
      total += 3;
      if (ferr1 !== 1'b1) begin bad++; $display("FAIL short_frame_err got %b required 1", ferr1); end
      if (lvl1 !== '0) begin bad++; $display("FAIL short_level got %0d required 0", lvl1); end
      if (tvalid1 !== 1'b0) begin bad++; $display("FAIL short_tvalid got %b required 0", tvalid1); end
      l = rand_slots();
      expect1(pack_slots(l));
      send_frame(l, rand_slots());
      wait_drain1("short_next");
      total++;
      if (ferr1 !== 1'b1) begin bad++; $display("FAIL short_sticky got %b required 1", ferr1); end
   endtask

   task automatic test_reset_mid();
      slots_t l;
      do_reset();
      start1  = 1'b1;
      tready1 = 1'b1;
      l = rand_slots();
      expect1(pack_slots(l));
      send_frame(l, rand_slots());
      wait_drain1("mid_pre");
      tready1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         l = rand_slots();
         expect1(pack_slots(l));
         send_frame(l, rand_slots());
      end
      repeat (3) @(negedge sck);
      #2;
      total += 2;
      if (lvl1 !== LW'(3)) begin bad++; $display("FAIL mid_level got %0d required 3", lvl1); end
      if (tvalid1 !== 1'b1) begin bad++; $display("FAIL mid_tvalid got %b required 1", tvalid1); end
      #1 rst = 1'b1;
      #1;
      total += 3;
      if ({tvalid1, tlast1, ferr1} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags got %b required 000", {tvalid1, tlast1, ferr1}); end
      if (tdata1 !== '0) begin bad++; $display("FAIL mid_rst_tdata got %h required 0", tdata1); end
      if ({ovf1, lvl1} !== '0) begin bad++; $display("FAIL mid_rst_counts got ovf=%0d level=%0d required 0 0", ovf1, lvl1); end
      q1.delete();
      beat1 = 0;
      @(negedge sck);
      rst     = 1'b0;
      tready1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         l = rand_slots();
         expect1(pack_slots(l));
         send_frame(l, rand_slots());
      end
      wait_drain1("mid_post");
   endtask

   task automatic test_mode();
      slots_t al, ar, bl, br;
      do_reset();
      start1  = 1'b0;
      tready2 = 1'b1;
      al = rand_slots();
      bl = rand_slots();
      for (int i = 0; i < NCH; i++) begin
         ar[i] = 32'hDEAD_0000 + i;
         br[i] = {16'h1234 + 16'(i), 16'($urandom)};
      end
      expect2(pack_slots(br));
      fork
         send_frame(al, ar);
         begin
            repeat (10) @(negedge sck);
            start2 = 1'b1;
         end
      join
      send_frame(bl, br);
      @(negedge sck);
      start2 = 1'b0;
      wait_drain2("mode");
      @(negedge sck); #2;
      total += 2;
      if (ferr2 !== 1'b0) begin bad++; $display("FAIL mode_frame_err got %b required 0", ferr2); end
      if (tvalid1 !== 1'b0) begin bad++; $display("FAIL mode_left_idle got tvalid=%b required 0", tvalid1); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_packet();
      test_overflow();
      test_short_slot();
      test_reset_mid();
      test_mode();
      repeat (4) @(negedge sck);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_axis_capture.md
Name: i2s_axis_capture

Overview:
- Parametrised successor to the fixed 8-ADC-plus-mux capture path: deserialises NUM_CH I2S data lines that share one sck/ws pair.
- Truncates the selected slot of each channel to OUT_W bits and assembles one frame word containing all channels.
- Buffers frame words in an internal FIFO and streams them out on AXI-Stream, with packet framing (tlast), overflow accounting and malformed-frame detection.
- Sits between the microphone/ADC I2S pins and the DMA AXI-Stream slave.

Parameters:
- NUM_CH, 8, number of I2S data lines (1..16).
- SLOT_W, 32, sck cycles per I2S slot (bits captured per channel).
- OUT_W, 16, bits kept per channel; MSBs of the slot word; OUT_W <= SLOT_W.
- RIGHT_SLOT, 0, 0 = capture left slot (ws low); 1 = capture right slot (ws high).
- FIFO_DEPTH, 16, frame words buffered; power of 2, >= 2.
- PKT_LEN, 256, accepted beats per packet; tlast on the last one; >= 1.
- CNT_W, 16, width of overflow_cnt.

Ports:
- sck  in  1  I2S bit clock; single clock domain; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  capture enable, level-sensitive.
- ws  in  1  I2S word select.
- sd  in  NUM_CH  serial data, bit i = channel i.
- S_AXIS_tready  in  1  downstream ready.
- S_AXIS_tdata  out  NUM_CH*OUT_W  frame word; channel 0 in bits [OUT_W-1:0].
- S_AXIS_tvalid  out  1  frame word valid.
- S_AXIS_tlast  out  1  last beat of packet.
- overflow_cnt  out  CNT_W  frames dropped because the FIFO was full; saturating.
- frame_err  out  1  sticky; a slot was cut short by a ws edge.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync to sck on release):
  - Outputs: tvalid=0, tlast=0, tdata=0, overflow_cnt=0, frame_err=0, fifo_level=0.
  - Internal: FIFO empty, beat counter 0, capture FSM in IDLE.
- Reset mid-operation discards any partial frame and any buffered frames.
- ws is registered every edge as ws_d. Slot-start edge:
  - RIGHT_SLOT=0: ws_d=1 and ws=0.
  - RIGHT_SLOT=1: ws_d=0 and ws=1.
- Capture FSM states IDLE, WAIT, SHIFT, PUSH:
  - IDLE: start=0. Go to WAIT when start=1.
  - WAIT: on slot-start edge go to SHIFT with bit_cnt=0. A partial slot in progress when start rises is never captured.
  - SHIFT: I2S one-bit delay. On each of the SLOT_W edges after the slot-start edge, shift sd[i] MSB-first into per-channel register i and increment bit_cnt. After bit SLOT_W is shifted, go to PUSH.
  - SHIFT abort: if ws toggles out of the selected level before SLOT_W bits are shifted, set frame_err, discard the frame and return to WAIT.
  - PUSH (one cycle): frame word = concatenation of shift[i][SLOT_W-1 -: OUT_W].
    - FIFO not full: write the word.
    - FIFO full: drop the word and increment overflow_cnt (saturates at all-ones).
    - Then go to WAIT, or IDLE if start=0.
  - start=0 seen in WAIT or SHIFT: go to IDLE and discard the partial frame. A frame already in PUSH completes.
- FIFO: show-ahead, registered.
  - tvalid = !empty; the head word is presented on tdata.
  - Latency from the PUSH edge to tvalid=1 is 1 sck when the FIFO was empty.
  - Pop on tvalid && tready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and no overflow is counted.
  - fifo_level updates on the edge after push/pop; it is unchanged on a simultaneous push and pop.
  - The FIFO keeps draining while start=0.
- Packet framing:
  - The beat counter counts accepted beats (tvalid && tready) only.
  - tlast = tvalid && (beat_cnt == PKT_LEN-1). The counter wraps to 0 after that beat.
  - Dropped frames are never counted.
  - The beat counter clears on reset only, not on start.
- AXI-Stream rules: tdata and tlast stay stable while tvalid=1 and tready=0. tvalid never deasserts without a handshake.
- frame_err clears on reset only.

Decomposition:
- Package i2s_capture_pkg:
  - capture FSM state typedef;
  - localparams for the tdata width (NUM_CH*OUT_W) and the level width.
- Sub-module axis_frame_fifo:
  - parametrised width/depth synchronous FIFO;
  - full/empty/level outputs;
  - show-ahead read;
  - simultaneous push/pop support.

Test Plan:
- Single frame: NUM_CH=8, left slot ch i = 32'hA5A50000+i, tready=1 -> one beat with tdata[16*i+:16]=16'hA5A5 for all i; tvalid rises 1 sck after PUSH.
- Packet framing: PKT_LEN=4, 10 frames, tready=1 -> tlast on beats 4 and 8 only; beats 9-10 tlast=0.
- Overflow: FIFO_DEPTH=4, tready=0, 7 frames -> fifo_level=4, overflow_cnt=3; then tready=1 -> exactly 4 beats, in order, with the first 4 frames' data.
- Short slot: ws low for only 20 sck -> frame_err=1, no push, fifo_level unchanged; the next well-formed frame is captured normally.
- Mode/start: RIGHT_SLOT=1, right data 32'h1234xxxx on ch0, start raised mid-right-slot -> the first partial slot is ignored; the first beat has tdata[15:0]=16'h1234.
- Reset mid-packet: assert rst with 3 words buffered and tvalid=1 -> all outputs 0 immediately (async); after release the first new frame is beat 0 of a new packet.
